// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default geometry, tap mask and the period-monitor
// FSM state encoding. Imported by the LFSR-side and monitor-side blocks.
package lfsr_pkg;

    localparam int                    LFSR_WIDTH        = 4;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS_DEFAULT = 4'b1100;

    // Longest legal period of a maximal-length LFSR of the default width.
    localparam logic [LFSR_WIDTH:0]   MAX_PERIOD        = 5'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } mon_state_t;

endpackage : lfsr_pkg

// File: rtl/lfsr_next_state.sv
// Combinational Fibonacci LFSR step: shift left, feed back the XOR of the
// tapped bits into bit 0. Shared by the LFSR and the period monitor.
module lfsr_next_state #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};

endmodule : lfsr_next_state

// File: rtl/lfsr_period_monitor.sv
// Period monitor for the LFSR state bus. Captures a reference state, counts
// enabled samples until the reference recurs, and flags all-zero lockup and
// sequences that never return. Every output is registered.
// Build option: define LFSR_PERIOD_MON_STEP_CHECK_EN to add a per-sample
// check of w against next(prev); otherwise step_err is tied low.
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] w,
    output logic             busy,
    output logic [WIDTH:0]   period,
    output logic             period_valid,
    output logic             maximal,
    output logic             lockup,
    output logic             timeout,
    output logic             step_err
);

    // Largest legal period and the count at which the sequence is declared
    // non-returning; the counter is one bit wider so neither overflows.
    localparam logic [WIDTH:0]   PERIOD_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0]   CNT_LIMIT  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] ZERO_STATE = {WIDTH{1'b0}};
    localparam logic [WIDTH:0]   CNT_ONE    = {{WIDTH{1'b0}}, 1'b1};

    mon_state_t       r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_ref,    w_ref_nxt;
    logic [WIDTH:0]   r_cnt,    w_cnt_nxt;
    logic [WIDTH:0]   r_period, w_period_nxt;
    logic             r_valid,  w_valid_nxt;
    logic             r_max,    w_max_nxt;
    logic             r_lock,   w_lock_nxt;
    logic             r_tout,   w_tout_nxt;
    logic             r_busy;
    logic [WIDTH:0]   w_cnt_inc;
    logic             w_is_zero;

    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_is_zero = (w == ZERO_STATE);

    // Next-state and next-output decode; en=0 leaves everything frozen.
    always_comb begin
        w_state_nxt  = r_state;
        w_ref_nxt    = r_ref;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_valid_nxt  = r_valid;
        w_max_nxt    = r_max;
        w_lock_nxt   = r_lock;
        w_tout_nxt   = r_tout;
        case (r_state)
            IDLE: begin
                if (en) begin
                    if (w_is_zero) begin
                        w_lock_nxt  = 1'b1;
                        w_state_nxt = FAULT;
                    end else begin
                        w_ref_nxt   = w;
                        w_cnt_nxt   = {(WIDTH+1){1'b0}};
                        w_state_nxt = COUNT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            COUNT: begin
                if (en) begin
                    if (w_is_zero) begin
                        w_lock_nxt  = 1'b1;
                        w_state_nxt = FAULT;
                    end else if (w == r_ref) begin
                        w_period_nxt = w_cnt_inc;
                        w_valid_nxt  = 1'b1;
                        w_max_nxt    = (w_cnt_inc == PERIOD_MAX);
                        w_state_nxt  = DONE;
                    end else if (w_cnt_inc == CNT_LIMIT) begin
                        w_tout_nxt  = 1'b1;
                        w_state_nxt = FAULT;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = COUNT;
                end
            end
            DONE:    w_state_nxt = DONE;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset dominates clear, both restart in IDLE.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state  <= IDLE;
            r_ref    <= {WIDTH{1'b0}};
            r_cnt    <= {(WIDTH+1){1'b0}};
            r_period <= {(WIDTH+1){1'b0}};
            r_valid  <= 1'b0;
            r_max    <= 1'b0;
            r_lock   <= 1'b0;
            r_tout   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ref    <= w_ref_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_valid  <= w_valid_nxt;
            r_max    <= w_max_nxt;
            r_lock   <= w_lock_nxt;
            r_tout   <= w_tout_nxt;
            r_busy   <= (w_state_nxt == COUNT);
        end
    end

    assign busy         = r_busy;
    assign period       = r_period;
    assign period_valid = r_valid;
    assign maximal      = r_max;
    assign lockup       = r_lock;
    assign timeout      = r_tout;

`ifdef LFSR_PERIOD_MON_STEP_CHECK_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_prev_next;
    logic             r_step_err;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .i_state (r_prev),
        .o_next  (w_prev_next)
    );

    // Track the previous sample and flag any non-zero sample that is not its successor.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_prev     <= {WIDTH{1'b0}};
            r_step_err <= 1'b0;
        end else if (en && (r_state == IDLE) && !w_is_zero) begin
            r_prev <= w;
        end else if (en && (r_state == COUNT)) begin
            r_prev <= w;
            if (!w_is_zero && (w != w_prev_next)) begin
                r_step_err <= 1'b1;
            end
        end
    end

    assign step_err = r_step_err;
`else
    assign step_err = 1'b0;
`endif

endmodule : lfsr_period_monitor

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor (WIDTH=4, TAPS=4'b1100). Expected
// values are hand-derived from the tap polynomial; the maximal sequence from
// seed 1111 is tabulated below.
module tb_lfsr_period_monitor;

`ifdef LFSR_PERIOD_MON_STEP_CHECK_EN
    localparam logic STEP_ON = 1'b1;
`else
    localparam logic STEP_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic       clear;
    logic [3:0] w;
    logic       busy;
    logic [4:0] period;
    logic       period_valid;
    logic       maximal;
    logic       lockup;
    logic       timeout;
    logic       step_err;

    int n_vec;
    int n_err;

    logic [3:0] seq [0:15];

    lfsr_period_monitor #(
        .WIDTH (4),
        .TAPS  (4'b1100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .clear        (clear),
        .w            (w),
        .busy         (busy),
        .period       (period),
        .period_valid (period_valid),
        .maximal      (maximal),
        .lockup       (lockup),
        .timeout      (timeout),
        .step_err     (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then settle just after the consuming edge.
    task automatic drive(input logic e, input logic c, input logic r, input logic [3:0] v);
        en    = e;
        clear = c;
        reset = r;
        w     = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, ".busy"},    32'(busy),         32'd0);
        check_eq({tag, ".period"},  32'(period),       32'd0);
        check_eq({tag, ".valid"},   32'(period_valid), 32'd0);
        check_eq({tag, ".maximal"}, 32'(maximal),      32'd0);
        check_eq({tag, ".lockup"},  32'(lockup),       32'd0);
        check_eq({tag, ".timeout"}, 32'(timeout),      32'd0);
        check_eq({tag, ".steperr"}, 32'(step_err),     32'd0);
    endtask

    task automatic check_max_result(input string tag);
        check_eq({tag, ".period"},  32'(period),       32'd15);
        check_eq({tag, ".valid"},   32'(period_valid), 32'd1);
        check_eq({tag, ".maximal"}, 32'(maximal),      32'd1);
        check_eq({tag, ".busy"},    32'(busy),         32'd0);
        check_eq({tag, ".lockup"},  32'(lockup),       32'd0);
        check_eq({tag, ".timeout"}, 32'(timeout),      32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        // Seed 1111, next = {s[2:0], s[3]^s[2]}; returns to 1111 after 15 steps.
        seq[0]  = 4'b1111; seq[1]  = 4'b1110; seq[2]  = 4'b1100; seq[3]  = 4'b1000;
        seq[4]  = 4'b0001; seq[5]  = 4'b0010; seq[6]  = 4'b0100; seq[7]  = 4'b1001;
        seq[8]  = 4'b0011; seq[9]  = 4'b0110; seq[10] = 4'b1101; seq[11] = 4'b1010;
        seq[12] = 4'b0101; seq[13] = 4'b1011; seq[14] = 4'b0111; seq[15] = 4'b1111;

        en = 1'b0; clear = 1'b0; reset = 1'b1; w = 4'b0000;
        drive(1'b1, 1'b0, 1'b1, 4'b0000);
        drive(1'b1, 1'b0, 1'b1, 4'b0101);
        check_idle_zero("reset");

        // Maximal sequence.
        drive(1'b1, 1'b0, 1'b0, seq[0]);
        check_eq("max.busy_after_capture", 32'(busy), 32'd1);
        for (int i = 1; i < 15; i++) drive(1'b1, 1'b0, 1'b0, seq[i]);
        check_eq("max.valid_before_return", 32'(period_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, seq[15]);
        check_max_result("max");
        check_eq("max.steperr", 32'(step_err), 32'd0);
        // DONE ignores further samples, even an all-zero one.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        check_eq("done_hold.lockup", 32'(lockup), 32'd0);
        check_eq("done_hold.period", 32'(period), 32'd15);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        check_idle_zero("clear_after_max");

        // Lockup from IDLE.
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        check_eq("lock.lockup", 32'(lockup),       32'd1);
        check_eq("lock.valid",  32'(period_valid), 32'd0);
        check_eq("lock.busy",   32'(busy),         32'd0);
        drive(1'b1, 1'b0, 1'b0, 4'b1111);
        check_eq("lock.fault_hold_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        check_idle_zero("lock.clear");

        // clear together with en: a zero sample must not cause lockup or capture.
        drive(1'b1, 1'b1, 1'b0, 4'b0000);
        check_eq("clr_en.lockup", 32'(lockup), 32'd0);
        check_eq("clr_en.busy",   32'(busy),   32'd0);
        drive(1'b1, 1'b1, 1'b0, 4'b1010);
        check_eq("clr_en.busy2",  32'(busy),   32'd0);

        // Stuck LFSR held at 1010: period 1.
        drive(1'b1, 1'b0, 1'b0, 4'b1010);
        check_eq("stuck.busy", 32'(busy), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'b1010);
        check_eq("stuck.period",  32'(period),       32'd1);
        check_eq("stuck.valid",   32'(period_valid), 32'd1);
        check_eq("stuck.maximal", 32'(maximal),      32'd0);
        check_eq("stuck.steperr", 32'(step_err),     32'(STEP_ON));
        drive(1'b0, 1'b1, 1'b0, 4'b0000);

        // Timeout: capture 0001, then 16 nonzero samples that never equal 0001.
        drive(1'b1, 1'b0, 1'b0, 4'b0001);
        for (int k = 1; k <= 15; k++) drive(1'b1, 1'b0, 1'b0, 4'((k % 14) + 2));
        check_eq("tout.before_16th", 32'(timeout), 32'd0);
        check_eq("tout.busy_15",     32'(busy),    32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'd4);
        check_eq("tout.timeout", 32'(timeout),      32'd1);
        check_eq("tout.valid",   32'(period_valid), 32'd0);
        check_eq("tout.busy",    32'(busy),         32'd0);
        check_eq("tout.lockup",  32'(lockup),       32'd0);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        check_idle_zero("tout.clear");

        // Gating: five en=0 cycles (with w=0) mid-count change nothing.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, seq[i]);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 4'b0000);
        check_eq("gate.lockup", 32'(lockup), 32'd0);
        check_eq("gate.busy",   32'(busy),   32'd1);
        for (int i = 8; i < 16; i++) drive(1'b1, 1'b0, 1'b0, seq[i]);
        check_max_result("gate");
        drive(1'b0, 1'b1, 1'b0, 4'b0000);

        // Reset at sample 7 aborts; a fresh run from IDLE still measures 15.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, seq[i]);
        drive(1'b1, 1'b0, 1'b1, seq[8]);
        check_idle_zero("abort");
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, seq[i]);
        check_max_result("restart");
        drive(1'b0, 1'b1, 1'b0, 4'b0000);

        // Step check: 0110 injected in place of 0100; period still 15.
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, (i == 6) ? 4'b0110 : seq[i]);
        check_eq("step.steperr", 32'(step_err), 32'(STEP_ON));
        check_eq("step.period",  32'(period),   32'd15);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 4'b0011);
        check_eq("step.held", 32'(step_err), 32'(STEP_ON));
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        check_idle_zero("step.clear");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_lfsr_period_monitor

// File: doc/lfsr_period_monitor.md
Name: lfsr_period_monitor

Overview:
- Downstream consumer of the 4-bit LFSR state bus `w`.
- Samples the LFSR state on every enabled cycle and measures the sequence period.
- Flags all-zero lockup, non-returning sequences (timeout) and maximal-length operation.
- Sits between the LFSR and the lab's status/display logic; used for self-check of seed and tap choices.

Parameters:
- WIDTH, 4: LFSR state width. The period counter is WIDTH+1 bits wide.
- TAPS, 4'b1100: feedback tap mask. next = {s[WIDTH-2:0], ^(s & TAPS)}. Used only by the optional step check.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample strobe; high when the LFSR is in run mode (its sel=1).
- clear  input  1  synchronous single-cycle restart of the measurement.
- w  input  WIDTH  current LFSR state.
- busy  output  1  measurement in progress (state COUNT).
- period  output  WIDTH+1  measured period; valid when period_valid=1.
- period_valid  output  1  period measured, held until clear/reset.
- maximal  output  1  period == 2^WIDTH-1; qualified by period_valid.
- lockup  output  1  sticky; an all-zero state was sampled.
- timeout  output  1  sticky; no return to the reference state within 2^WIDTH samples.
- step_err  output  1  sticky step-check mismatch (optional feature; tied 0 when excluded).

Behaviour:
- Reset: all outputs 0; internal ref, prev and cnt cleared; FSM goes to IDLE.
- clear: same effect as reset, but only when reset=0. Reset dominates clear.
- clear with en in the same cycle: clear wins and the sample is discarded.
- All outputs are registered. Each flag or period asserts on the edge that consumes the causing sample, so it is visible in the cycle after that sample.
- Cycles with en=0 are ignored in every state; cnt, ref and prev are frozen.
- FSM states: IDLE, COUNT, DONE, FAULT.
- IDLE, en=1, w!=0: ref<=w, prev<=w, cnt<=0, go to COUNT.
- IDLE, en=1, w==0: lockup<=1, go to FAULT.
- COUNT, en=1, evaluated in this priority order:
  - w==0: lockup<=1, go to FAULT.
  - w==ref: period<=cnt+1, period_valid<=1, maximal<=(cnt+1 == 2^WIDTH-1), go to DONE.
  - cnt+1 == 2^WIDTH: timeout<=1, go to FAULT.
  - otherwise: cnt<=cnt+1.
  - prev<=w on every en cycle in COUNT.
- A non-advancing LFSR (w held) gives period=1.
- For WIDTH=4, the maximum legal period is 15 and timeout fires on the 16th post-capture sample.
- DONE and FAULT hold all outputs; en is ignored; the only exit is clear or reset.
- Counter arithmetic is unsigned, WIDTH+1 bits, and never wraps, because the timeout compare precedes overflow.
- Reset or clear mid-COUNT aborts the measurement. No partial period is reported.

Optional Feature:
- Macro: LFSR_PERIOD_MON_STEP_CHECK_EN.
- Defined: on each en cycle in COUNT, compare w against next(prev) using TAPS.
  - A mismatch sets step_err (sticky until clear/reset).
  - The FSM proceeds unaffected.
  - The w==0 sample is not step-checked (lockup covers it).
- Undefined: no prev-next logic is instantiated and step_err is driven constant 0. The port list is unchanged.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_WIDTH=4
  - LFSR_TAPS_DEFAULT=4'b1100
  - FSM state typedef {IDLE, COUNT, DONE, FAULT}
  - MAX_PERIOD constant
- One sub-module: lfsr_next_state (combinational, parameterised WIDTH/TAPS, produces next state). It is shared with the LFSR itself and instantiated here only under the macro.

Test Plan:
- Maximal sequence: reset, then drive the LFSR from seed 1111 with TAPS 1100 and en=1. The sequence returns to 1111 after 15 samples. Required: period_valid=1, period=15, maximal=1, busy=0, lockup=timeout=0.
- Lockup: en=1 with w=0000 in IDLE. Required: lockup=1 the next cycle, FSM in FAULT, period_valid=0. Then clear → all flags 0.
- Stuck LFSR: w held at 1010 with en=1. Required: period=1, period_valid=1, maximal=0.
- Timeout: capture 0001, then feed 16 nonzero samples that never equal 0001. Required: timeout=1 after the 16th, period_valid=0.
- Gating and abort:
  - Toggle en low for 5 cycles mid-count. Required: the final period is unchanged (15).
  - Assert reset at sample 7. Required: all outputs 0 and a restart from IDLE.
  - Assert clear+en together. Required: the sample is dropped.
- Step check (macro defined): inject 0110 in place of the expected next state mid-sequence. Required: step_err=1 and held. With the macro undefined, step_err stays 0 throughout.
